// File: rtl/slow_path_send_pkt_q.sv
// Slow-path SYN-ACK header queue: buffers new-flow reply headers from RX and
// drains them to the TX send engine over a show-ahead val/rdy interface.
module slow_path_send_pkt_q #(
  parameter int DEPTH_LOG2     = 2,
  parameter bit DROP_WHEN_FULL = 1'b0,
  parameter int DROP_CNT_W     = 16,
  parameter int PKT_W          = 160,
  parameter int FLOWID_W       = 8,
  parameter int IP_ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enq_val,
  output logic                  o_enq_rdy,
  input  logic [PKT_W-1:0]      i_enq_pkt,
  input  logic [FLOWID_W-1:0]   i_enq_flowid,
  input  logic [IP_ADDR_W-1:0]  i_enq_src_ip,
  input  logic [IP_ADDR_W-1:0]  i_enq_dst_ip,
  output logic                  o_deq_val,
  input  logic                  i_deq_rdy,
  output logic [PKT_W-1:0]      o_deq_pkt,
  output logic [FLOWID_W-1:0]   o_deq_flowid,
  output logic [IP_ADDR_W-1:0]  o_deq_src_ip,
  output logic [IP_ADDR_W-1:0]  o_deq_dst_ip,
  output logic [DEPTH_LOG2:0]   o_occupancy,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int ENTRY_W = PKT_W + FLOWID_W + 2 * IP_ADDR_W;

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_deq_fire;
  logic                  w_enq_rdy;
  logic                  w_wr_en;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                      (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_deq_fire = !w_empty && i_deq_rdy;

  // In drop mode a full queue still accepts when the head leaves in the same
  // cycle; in backpressure mode enq_rdy depends only on registered state.
  always_comb begin
    w_enq_rdy = 1'b1;
    w_wr_en   = 1'b0;
    w_drop    = 1'b0;
    if (DROP_WHEN_FULL) begin
      w_wr_en = i_enq_val && (!w_full || w_deq_fire);
      w_drop  = i_enq_val && w_full && !w_deq_fire;
    end else begin
      w_enq_rdy = !w_full;
      w_wr_en   = i_enq_val && !w_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Payload storage needs no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {i_enq_pkt, i_enq_flowid, i_enq_src_ip, i_enq_dst_ip};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign w_head       = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign o_enq_rdy    = w_enq_rdy;
  assign o_deq_val    = !w_empty;
  assign o_deq_pkt    = w_head[ENTRY_W-1 -: PKT_W];
  assign o_deq_flowid = w_head[2*IP_ADDR_W +: FLOWID_W];
  assign o_deq_src_ip = w_head[IP_ADDR_W +: IP_ADDR_W];
  assign o_deq_dst_ip = w_head[0 +: IP_ADDR_W];
  assign o_occupancy  = r_wr_ptr - r_rd_ptr;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_slow_path_send_pkt_q.sv
// Self-checking bench for slow_path_send_pkt_q: one backpressure instance and
// one drop-mode instance share stimulus and are checked against queue models.
module tb_slow_path_send_pkt_q;

   localparam int DEPTH   = 4;
   localparam int DROP_W  = 3;
   localparam int DROPMAX = 7;
   localparam int NV      = 17;

   typedef struct packed {
      logic [31:0] pkt;
      logic [7:0]  flow;
      logic [31:0] src;
      logic [31:0] dst;
   } entry_t;

   typedef struct {
      bit enqVal;
      bit deqRdy;
      int flow;
      int occ0;
      bit rdy0;
      int head0;
      int occ1;
      int drop1;
      int head1;
   } vec_t;

   logic clk;
   logic rst_n;
   logic enqVal;
   logic deqRdy;
   entry_t enqE;

   logic enqRdy0, deqVal0, enqRdy1, deqVal1;
   logic [31:0] deqPkt0, deqSrc0, deqDst0, deqPkt1, deqSrc1, deqDst1;
   logic [7:0] deqFlow0, deqFlow1;
   logic [2:0] occ0, occ1;
   logic [DROP_W-1:0] drop0, drop1;

   int checks;
   int failures;
   entry_t q0[$];
   entry_t q1[$];
   int mDrop1;
   vec_t tbl[NV];

   slow_path_send_pkt_q #(
      .DEPTH_LOG2(2), .DROP_WHEN_FULL(1'b0), .DROP_CNT_W(DROP_W),
      .PKT_W(32), .FLOWID_W(8), .IP_ADDR_W(32)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_enq_val(enqVal), .o_enq_rdy(enqRdy0),
      .i_enq_pkt(enqE.pkt), .i_enq_flowid(enqE.flow),
      .i_enq_src_ip(enqE.src), .i_enq_dst_ip(enqE.dst),
      .o_deq_val(deqVal0), .i_deq_rdy(deqRdy),
      .o_deq_pkt(deqPkt0), .o_deq_flowid(deqFlow0),
      .o_deq_src_ip(deqSrc0), .o_deq_dst_ip(deqDst0),
      .o_occupancy(occ0), .o_drop_cnt(drop0)
   );

   slow_path_send_pkt_q #(
      .DEPTH_LOG2(2), .DROP_WHEN_FULL(1'b1), .DROP_CNT_W(DROP_W),
      .PKT_W(32), .FLOWID_W(8), .IP_ADDR_W(32)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_enq_val(enqVal), .o_enq_rdy(enqRdy1),
      .i_enq_pkt(enqE.pkt), .i_enq_flowid(enqE.flow),
      .i_enq_src_ip(enqE.src), .i_enq_dst_ip(enqE.dst),
      .o_deq_val(deqVal1), .i_deq_rdy(deqRdy),
      .o_deq_pkt(deqPkt1), .o_deq_flowid(deqFlow1),
      .o_deq_src_ip(deqSrc1), .o_deq_dst_ip(deqDst1),
      .o_occupancy(occ1), .o_drop_cnt(drop1)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic entry_t mkEntry(int f);
      entry_t e;
      e.flow = 8'(f);
      e.pkt  = {4{e.flow}};
      e.src  = 32'hC0A80000 | 32'(f);
      e.dst  = 32'h0A000000 | 32'(f);
      return e;
   endfunction

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkValue(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Compares both instances against the reference queues before the next edge.
   task automatic checkOutput();
      checkValue("occ0", 128'(occ0), 128'(q0.size()));
      checkValue("deqVal0", 128'(deqVal0), 128'(q0.size() > 0));
      checkValue("enqRdy0", 128'(enqRdy0), 128'(q0.size() < DEPTH));
      checkValue("drop0", 128'(drop0), 128'(0));
      if (q0.size() > 0)
         checkValue("head0", 128'({deqPkt0, deqFlow0, deqSrc0, deqDst0}), 128'(q0[0]));
      checkValue("occ1", 128'(occ1), 128'(q1.size()));
      checkValue("deqVal1", 128'(deqVal1), 128'(q1.size() > 0));
      checkValue("enqRdy1", 128'(enqRdy1), 128'(1));
      checkValue("drop1", 128'(drop1), 128'(mDrop1));
      if (q1.size() > 0)
         checkValue("head1", 128'({deqPkt1, deqFlow1, deqSrc1, deqDst1}), 128'(q1[0]));
   endtask

   // Compares against the hand-written expectations of one table row.
   task automatic checkTableRow(vec_t v, int r);
      checkValue($sformatf("row%0d_occ0", r), 128'(occ0), 128'(v.occ0));
      checkValue($sformatf("row%0d_rdy0", r), 128'(enqRdy0), 128'(v.rdy0));
      checkValue($sformatf("row%0d_val0", r), 128'(deqVal0), 128'(v.head0 >= 0));
      if (v.head0 >= 0)
         checkValue($sformatf("row%0d_head0", r),
                    128'({deqPkt0, deqFlow0, deqSrc0, deqDst0}), 128'(mkEntry(v.head0)));
      checkValue($sformatf("row%0d_occ1", r), 128'(occ1), 128'(v.occ1));
      checkValue($sformatf("row%0d_drop1", r), 128'(drop1), 128'(v.drop1));
      checkValue($sformatf("row%0d_val1", r), 128'(deqVal1), 128'(v.head1 >= 0));
      if (v.head1 >= 0)
         checkValue($sformatf("row%0d_head1", r),
                    128'({deqPkt1, deqFlow1, deqSrc1, deqDst1}), 128'(mkEntry(v.head1)));
   endtask

   // Drives one cycle of stimulus, checks the model, then advances the model.
   task automatic applyStimulus(bit ev, bit dr, entry_t e);
      bit deq0, deq1, full1;
      enqVal = ev;
      deqRdy = dr;
      enqE   = e;
      checkOutput();
      deq0  = (q0.size() > 0) && dr;
      deq1  = (q1.size() > 0) && dr;
      full1 = (q1.size() == DEPTH);
      if (ev && q0.size() < DEPTH) begin
         if (deq0) void'(q0.pop_front());
         q0.push_back(e);
      end else if (deq0) begin
         void'(q0.pop_front());
      end
      if (deq1) void'(q1.pop_front());
      if (ev && (!full1 || deq1)) q1.push_back(e);
      else if (ev && mDrop1 < DROPMAX) mDrop1++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      entry_t e;
      checks   = 0;
      failures = 0;
      mDrop1   = 0;
      rst_n    = 1'b0;
      enqVal   = 1'b0;
      deqRdy   = 1'b0;
      enqE     = '0;

      // enqVal deqRdy flow | occ0 rdy0 head0 | occ1 drop1 head1 (head -1 = empty)
      tbl[0]  = '{1, 0, 1,  0, 1, -1,  0, 0, -1};
      tbl[1]  = '{1, 0, 2,  1, 1,  1,  1, 0,  1};
      tbl[2]  = '{1, 0, 3,  2, 1,  1,  2, 0,  1};
      tbl[3]  = '{1, 0, 4,  3, 1,  1,  3, 0,  1};
      tbl[4]  = '{1, 0, 5,  4, 0,  1,  4, 0,  1};
      tbl[5]  = '{1, 0, 5,  4, 0,  1,  4, 1,  1};
      tbl[6]  = '{1, 0, 5,  4, 0,  1,  4, 2,  1};
      tbl[7]  = '{1, 1, 6,  4, 0,  1,  4, 3,  1};
      tbl[8]  = '{1, 0, 5,  3, 1,  2,  4, 3,  2};
      tbl[9]  = '{0, 1, 0,  4, 0,  2,  4, 4,  2};
      tbl[10] = '{0, 1, 0,  3, 1,  3,  3, 4,  3};
      tbl[11] = '{0, 1, 0,  2, 1,  4,  2, 4,  4};
      tbl[12] = '{0, 1, 0,  1, 1,  5,  1, 4,  6};
      tbl[13] = '{0, 1, 0,  0, 1, -1,  0, 4, -1};
      tbl[14] = '{1, 1, 3,  0, 1, -1,  0, 4, -1};
      tbl[15] = '{0, 1, 0,  1, 1,  3,  1, 4,  3};
      tbl[16] = '{0, 0, 0,  0, 1, -1,  0, 4, -1};

      repeat (2) @(negedge clk);
      checkOutput();
      rst_n = 1'b1;

      for (int r = 0; r < NV; r++) begin
         checkTableRow(tbl[r], r);
         applyStimulus(tbl[r].enqVal, tbl[r].deqRdy, mkEntry(tbl[r].flow));
      end

      // Long random stream: pointers wrap many times and the drop counter saturates.
      for (int i = 0; i < 300; i++) begin
         e.pkt  = $urandom;
         e.flow = 8'($urandom_range(0, 255));
         e.src  = $urandom;
         e.dst  = $urandom;
         applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < ((i < 150) ? 35 : 65), e);
      end

      applyStimulus(1'b1, 1'b0, mkEntry(11));
      applyStimulus(1'b1, 1'b0, mkEntry(12));
      enqVal = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkValue("rst_deqVal0", 128'(deqVal0), 128'(0));
      checkValue("rst_occ0", 128'(occ0), 128'(0));
      checkValue("rst_enqRdy0", 128'(enqRdy0), 128'(1));
      checkValue("rst_deqVal1", 128'(deqVal1), 128'(0));
      checkValue("rst_occ1", 128'(occ1), 128'(0));
      checkValue("rst_drop1", 128'(drop1), 128'(0));
      q0.delete();
      q1.delete();
      mDrop1 = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, 1'b0, mkEntry(3));
      applyStimulus(1'b0, 1'b1, mkEntry(0));
      applyStimulus(1'b0, 1'b0, mkEntry(0));
      checkOutput();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
